muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide unit with its own sequencing FSM. It executes MULT, MULTU, DIV and DIVU one bit per cycle and owns the HI/LO result registers. The main Control FSM starts it with start/op and waits on busy/done before reading hi/lo. It sits beside the ALU and drives the HI/LO inputs of the ALUOut source mux.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_sequencer.sv | 178 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and default sizes for the multiply/divide sequencer
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring-divide iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic [WIDTH-1:0] i_sreg,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_sreg
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_qbit;

  // Multiply adds the multiplicand into the upper half; divide trial-subtracts the divisor
  assign w_sum   = {1'b0, i_acc} + {1'b0, i_opnd};
  assign w_shift = {i_acc, i_sreg[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_opnd};
  assign w_qbit  = ~w_diff[WIDTH];

  // Select the next {acc, sreg} pair: product shifts right, quotient bits shift in from the right
  always_comb begin
    o_acc  = i_acc;
    o_sreg = i_sreg;
    if (i_is_div) begin
      o_acc  = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      o_sreg = {i_sreg[WIDTH-2:0], w_qbit};
    end else if (i_sreg[0]) begin
      {o_acc, o_sreg} = {w_sum, i_sreg[WIDTH-1:1]};
    end else begin
      {o_acc, o_sreg} = {1'b0, i_acc, i_sreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO (option: MULDIV_EARLY_OUT_EN)
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] oper_a,
  input  logic [WIDTH-1:0] oper_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic [CNT_W-1:0] iter_count
);

  muldiv_state_t      r_state;
  muldiv_state_t      w_next_state;
  muldiv_op_t         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_sreg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;

  logic               w_is_div;
  logic               w_is_signed;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_step_acc;
  logic [WIDTH-1:0]   w_step_sreg;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic               w_early;

  assign w_is_div    = r_op[1];
  assign w_is_signed = ~r_op[0];
  assign w_sign_a    = w_is_signed & r_a[WIDTH-1];
  assign w_sign_b    = w_is_signed & r_b[WIDTH-1];
  assign w_abs_a     = w_sign_a ? -r_a : r_a;
  assign w_abs_b     = w_sign_b ? -r_b : r_b;
  assign w_prod      = {r_acc, r_sreg};
  assign w_prod_fix  = r_neg_q ? -w_prod : w_prod;

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0]   w_rem_mask;
  logic [2*WIDTH-1:0] w_aligned;

  // Low r_cnt bits of sreg are the multiplier bits not yet consumed; if all zero only shifts remain
  assign w_rem_mask = ~({WIDTH{1'b1}} << r_cnt);
  assign w_aligned  = w_prod >> r_cnt;
  assign w_early    = ~w_is_div & ((r_sreg & w_rem_mask) == '0);
`else
  assign w_early    = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (w_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .i_sreg   (r_sreg),
    .o_acc    (w_step_acc),
    .o_sreg   (w_step_sreg)
  );

  // State register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; start is only honoured in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = PREP;
      PREP:    w_next_state = (w_is_div && r_b == '0) ? DONE : RUN;
      RUN:     if (w_early || r_cnt == CNT_W'(1)) w_next_state = FIX;
      FIX:     w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (r_state != IDLE) busy = 1'b1;
    if (r_state == DONE) done = 1'b1;
  end

  // Datapath: capture, sign strip, iterate, sign fix and result write-back
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_op       <= MULT;
      r_a        <= '0;
      r_b        <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_sreg     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op       <= muldiv_op_t'(op);
            r_a        <= oper_a;
            r_b        <= oper_b;
            r_div_zero <= 1'b0;
          end
        end
        PREP: begin
          r_acc   <= '0;
          r_cnt   <= CNT_W'(WIDTH);
          r_neg_q <= w_sign_a ^ w_sign_b;
          r_neg_r <= w_sign_a;
          if (w_is_div) begin
            r_opnd     <= w_abs_b;
            r_sreg     <= w_abs_a;
            r_div_zero <= (r_b == '0);
          end else begin
            r_opnd <= w_abs_a;
            r_sreg <= w_abs_b;
          end
        end
        RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
          if (w_early) begin
            r_acc  <= w_aligned[2*WIDTH-1:WIDTH];
            r_sreg <= w_aligned[WIDTH-1:0];
            r_cnt  <= '0;
          end else
`endif
          begin
            r_acc  <= w_step_acc;
            r_sreg <= w_step_sreg;
            r_cnt  <= r_cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (w_is_div) begin
            r_hi <= r_neg_r ? -r_acc : r_acc;
            r_lo <= r_neg_q ? -r_sreg : r_sreg;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi         = r_hi;
  assign lo         = r_lo;
  assign div_zero   = r_div_zero;
  assign iter_count = r_cnt;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] oper_a;
  logic [31:0] oper_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;
  logic [5:0]  iter_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] pend_hi, pend_lo, held_hi, held_lo;
  bit          pend_dz, held_dz;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op),
    .oper_a(oper_a), .oper_b(oper_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero), .iter_count(iter_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from 64-bit arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml, output bit dz);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    mh = '0;
    ml = '0;
    case (o)
      2'b00: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
      2'b01: begin up = ua * ub; mh = up[63:32]; ml = up[31:0]; end
      2'b10: if (b == 0) dz = 1'b1;
             else begin q = sa / sb; r = sa % sb; mh = r[31:0]; ml = q[31:0]; end
      default: if (b == 0) dz = 1'b1;
               else begin uq = ua / ub; ur = ua % ub; mh = ur[31:0]; ml = uq[31:0]; end
    endcase
  endfunction

  // Cycles from the start edge to the cycle where done is high
  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] m;
    int run;
`endif
    if (o[1]) return (b == 0) ? 2 : 35;
`ifdef MULDIV_EARLY_OUT_EN
    m = (o == 2'b00 && b[31]) ? -b : b;
    run = 1;
    for (int i = 0; i < 32; i++) if (m[i]) run = (i + 2 > 32) ? 32 : i + 2;
    return run + 3;
`else
    return 35;
`endif
  endfunction

  // Every cycle: hi/lo must hold the last successful result; div_zero checked outside an operation
  always @(negedge Clk) begin
    if (reset) begin
      held_hi = '0;
      held_lo = '0;
      held_dz = 1'b0;
    end else begin
      if (done) begin
        if (!pend_dz) begin
          held_hi = pend_hi;
          held_lo = pend_lo;
        end
        held_dz = pend_dz;
      end
      chk("hi", 64'(hi), 64'(held_hi));
      chk("lo", 64'(lo), 64'(held_lo));
      if (!busy || done) chk("div_zero", 64'(div_zero), 64'(held_dz));
    end
  end

  // mode 0: plain; 1: stray start in RUN then reset at iter_count 10; 2: start during DONE
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
    int lat, busy_cnt, want;
    bit seen;
    logic [31:0] mh, ml;
    bit dz;
    model(o, a, b, mh, ml, dz);
    pend_hi = mh;
    pend_lo = ml;
    pend_dz = dz;
    want = exp_latency(o, b);
    @(negedge Clk);
    start = 1'b1; op = o; oper_a = a; oper_b = b;
    @(posedge Clk);
    #1;
    start = 1'b0; op = 2'($urandom_range(0, 3)); oper_a = $urandom; oper_b = $urandom;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge Clk);
      lat++;
      if (busy) busy_cnt++;
      if (lat == 1) chk("dz_clear_on_start", 64'(div_zero), 64'd0);
      if (lat == 2 && want > 2) chk("iter_load", 64'(iter_count), 64'd32);
      if (mode == 1 && lat == 5) start = 1'b1;
      if (mode == 1 && lat == 6) start = 1'b0;
      if (mode == 1 && lat > 2 && iter_count == 6'd10) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        chk("rst_iter", 64'(iter_count), 64'd0);
        @(negedge Clk);
        @(posedge Clk);
        #1 reset = 1'b0;
        return;
      end
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(lat), 64'(want));
    chk("busy_cycles", 64'(busy_cnt), 64'(want));
    if (mode == 2) begin
      start = 1'b1;
      @(posedge Clk);
      #1 start = 1'b0;
    end
    @(negedge Clk);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] mh, ml;
    bit dz;
    reset = 1'b1; start = 1'b0; op = 2'b00; oper_a = '0; oper_b = '0;
    pend_hi = '0; pend_lo = '0; pend_dz = 1'b0;
    repeat (3) @(posedge Clk);
    #1 reset = 1'b0;
    @(negedge Clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_dz", 64'(div_zero), 64'd0);
    chk("reset_iter", 64'(iter_count), 64'd0);

    // Hand-computed anchors for the reference model
    model(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, mh, ml, dz);
    chk("model_multu", {mh, ml}, 64'hFFFFFFFE_00000001);
    model(2'b00, 32'hFFFFFFFD, 32'd5, mh, ml, dz);
    chk("model_mult", {mh, ml}, 64'hFFFFFFFF_FFFFFFF1);
    model(2'b10, 32'hFFFFFFF9, 32'd2, mh, ml, dz);
    chk("model_div", {mh, ml}, 64'hFFFFFFFF_FFFFFFFD);
    model(2'b11, 32'd100, 32'd7, mh, ml, dz);
    chk("model_divu", {mh, ml}, {32'd2, 32'd14});
    model(2'b10, 32'h80000000, 32'hFFFFFFFF, mh, ml, dz);
    chk("model_div_ovf", {mh, ml}, 64'h00000000_80000000);

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(2'b10, 32'd10, 32'd0, 0);
    run_op(2'b11, 32'd77, 32'd0, 0);
    run_op(2'b01, 32'd3, 32'd3, 0);
    run_op(2'b01, 32'h12345678, 32'hF0000001, 1);
    run_op(2'b11, 32'd1000, 32'd3, 0);
    run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 2);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 0);

    run_op(2'b01, 32'd1234, 32'd1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
